// File: rtl/sig_framer.sv
// rtl/sig_framer.sv - tags an upstream word stream into C/Z/H signature sections behind a 2-entry FIFO.
// Optional macro SIG_FRAMER_STALL_CNT_EN adds the stall_cnt output.
module sig_framer #(
  parameter int W     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             order,
  input  logic [CNT_W-1:0] z_words,
  input  logic [CNT_W-1:0] h_words,
  input  logic [CNT_W-1:0] c_words,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_data,
  output logic [1:0]       m_sec,
  output logic             m_last,
  output logic             busy,
  output logic             done
`ifdef SIG_FRAMER_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, SEC0, SEC1, SEC2, DRAIN} state_e;

  localparam int EW = W + 3;

  state_e           state_q, state_d;
  logic             order_q;
  logic [CNT_W-1:0] len0_q, len1_q, len2_q;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [EW-1:0]    mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       fill_q, fill_d;
  logic             s_ready_q, busy_q, done_q;

  logic             start_acc, push, pop, word_end, finish, head_last;
  logic [CNT_W-1:0] in_len0, in_len1, in_len2, cur_len;
  logic [1:0]       cur_tag;
  state_e           first_sec, after_sec;

  // Slot lengths in transmission order: order=1 -> Z,H,C; order=0 -> C,Z,H.
  assign in_len0 = order ? z_words : c_words;
  assign in_len1 = order ? h_words : z_words;
  assign in_len2 = order ? c_words : h_words;

  assign first_sec = (in_len0 != '0) ? SEC0 :
                     (in_len1 != '0) ? SEC1 :
                     (in_len2 != '0) ? SEC2 : DRAIN;

  assign start_acc = start & (state_q == IDLE) & ~done_q;
  assign push      = s_valid & s_ready_q;
  assign pop       = (fill_q != 2'd0) & m_ready;
  assign head_last = mem_q[rd_ptr_q][EW-1];

  always_comb begin
    cur_len   = '0;
    cur_tag   = 2'd0;
    after_sec = DRAIN;
    case (state_q)
      SEC0: begin
        cur_len   = len0_q;
        cur_tag   = order_q ? 2'd1 : 2'd0;
        after_sec = (len1_q != '0) ? SEC1 : ((len2_q != '0) ? SEC2 : DRAIN);
      end
      SEC1: begin
        cur_len   = len1_q;
        cur_tag   = order_q ? 2'd2 : 2'd1;
        after_sec = (len2_q != '0) ? SEC2 : DRAIN;
      end
      SEC2: begin
        cur_len   = len2_q;
        cur_tag   = order_q ? 2'd0 : 2'd2;
        after_sec = DRAIN;
      end
      default: ;
    endcase
  end

  // Only nonzero sections are ever entered, so cur_len-1 cannot underflow there.
  assign word_end = (sec_cnt_q == cur_len - CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          sec_cnt_d = '0;
          if (first_sec == DRAIN) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = first_sec;
          end
        end
      end
      SEC0, SEC1, SEC2: begin
        if (push) begin
          if (word_end) begin
            sec_cnt_d = '0;
            state_d   = after_sec;
          end else begin
            sec_cnt_d = sec_cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_d = fill_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      order_q   <= 1'b0;
      len0_q    <= '0;
      len1_q    <= '0;
      len2_q    <= '0;
      sec_cnt_q <= '0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      fill_q    <= 2'd0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
      fill_q    <= fill_d;
      if (start_acc) begin
        order_q <= order;
        len0_q  <= in_len0;
        len1_q  <= in_len1;
        len2_q  <= in_len2;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= {word_end && (after_sec == DRAIN), cur_tag, s_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      s_ready_q <= ((state_d == SEC0) || (state_d == SEC1) || (state_d == SEC2)) &&
                   (fill_d != 2'd2);
      busy_q    <= (state_d != IDLE);
      done_q    <= finish;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = (fill_q != 2'd0);
  assign {m_last, m_sec, m_data} = mem_q[rd_ptr_q];
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef SIG_FRAMER_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cnt_q <= '0;
    end else if (busy_q && m_valid && !m_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sig_framer.sv
// tb/tb_sig_framer.sv - randomized self-checking bench for sig_framer against a section/queue model.
module tb_sig_framer;
  localparam int W     = 64;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, order;
  logic [CNT_W-1:0] z_words, h_words, c_words;
  logic             s_valid, s_ready;
  logic [W-1:0]     s_data;
  logic             m_valid, m_ready;
  logic [W-1:0]     m_data;
  logic [1:0]       m_sec;
  logic             m_last, busy, done;
`ifdef SIG_FRAMER_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  always #5 clk = ~clk;

  sig_framer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .order(order),
    .z_words(z_words), .h_words(h_words), .c_words(c_words),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sec(m_sec), .m_last(m_last), .busy(busy), .done(done)
`ifdef SIG_FRAMER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   sec;
    logic         last;
  } word_t;

  word_t        exp_q[$];
  logic [W-1:0] src_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame: sections in transmission order, each repeated by its length.
  task automatic build(input logic ord, input int z, input int h, input int c);
    int    lens[3];
    int    seq[3];
    word_t w;
    lens[0] = c; lens[1] = z; lens[2] = h;
    if (ord) begin seq[0] = 1; seq[1] = 2; seq[2] = 0; end
    else     begin seq[0] = 0; seq[1] = 1; seq[2] = 2; end
    exp_q.delete();
    src_q.delete();
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < lens[seq[s]]; i++) begin
        w.data = {$urandom(), $urandom()};
        w.sec  = 2'(seq[s]);
        w.last = 1'b0;
        exp_q.push_back(w);
        src_q.push_back(w.data);
      end
    end
    if (exp_q.size() > 0) begin
      w = exp_q.pop_back();
      w.last = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic pulse_start(input logic ord, input int z, input int h, input int c);
    start   = 1'b1;
    order   = ord;
    z_words = CNT_W'(z);
    h_words = CNT_W'(h);
    c_words = CNT_W'(c);
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: continuous; 1: m_ready low for cycles 3..7; 2: random valid/ready.
  task automatic run_frame(input int mode, input bit restart_mid, input bit start_at_done);
    int           idx, oidx, total;
    bit           exp_done, pend, finished, hold;
    logic [W-1:0] held_data;
    logic [2:0]   held_tag;
    idx = 0; oidx = 0; total = exp_q.size();
    exp_done = (total == 0); pend = exp_done; finished = 1'b0; hold = 1'b0;
    held_data = '0; held_tag = '0;
    for (int k = 0; k < 2000; k++) begin
      start = (restart_mid && k == 1) || (start_at_done && exp_done);
      if (start) begin
        order   = ~order;
        z_words = CNT_W'(1);
        h_words = CNT_W'(1);
        c_words = CNT_W'(1);
      end
      s_valid = (idx < total) && (mode != 2 || $urandom_range(0, 3) != 0);
      if (idx < total) s_data = src_q[idx];
      if (mode == 1)      m_ready = !(k >= 3 && k <= 7);
      else if (mode == 2) m_ready = ($urandom_range(0, 3) != 0);
      else                m_ready = 1'b1;
      if (exp_done) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("mvalid_at_done", 64'(m_valid), 64'd0);
        finished = 1'b1;
        break;
      end
      if (done) chk("done_early", 64'(done), 64'd0);
      if (hold) begin
        chk("hold_data", m_data, held_data);
        chk("hold_tag", 64'({m_last, m_sec}), 64'(held_tag));
      end
      if (mode == 1 && k == 7) begin
        chk("stall_sready_low", 64'(s_ready), 64'd0);
        chk("stall_mvalid", 64'(m_valid), 64'd1);
      end
      if (m_valid && m_ready) begin
        if (oidx < total) begin
          chk("m_data", m_data, exp_q[oidx].data);
          chk("m_sec", 64'(m_sec), 64'(exp_q[oidx].sec));
          chk("m_last", 64'(m_last), 64'(exp_q[oidx].last));
        end
        oidx++;
        if (oidx == total) pend = 1'b1;
      end
      if (s_valid && s_ready) idx++;
      hold      = m_valid && !m_ready;
      held_data = m_data;
      held_tag  = {m_last, m_sec};
      exp_done  = pend;
      @(negedge clk);
    end
    chk("frame_finished", 64'(finished), 64'd1);
    chk("words_in", 64'(idx), 64'(total));
    chk("words_out", 64'(oidx), 64'(total));
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b0;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_m_sec"},   64'(m_sec),   64'd0);
    chk({tag, "_m_last"},  64'(m_last),  64'd0);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_done"},    64'(done),    64'd0);
    chk({tag, "_m_data"},  m_data,       64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    rst = 1'b1; start = 1'b0; order = 1'b0;
    z_words = '0; h_words = '0; c_words = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
`ifdef SIG_FRAMER_STALL_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Z,H,C frame with an ignored mid-frame start.
    build(1'b1, 3, 2, 1); pulse_start(1'b1, 3, 2, 1); run_frame(0, 1'b1, 1'b0);
    // C,Z,H frame with a start coinciding with done.
    build(1'b0, 3, 2, 1); pulse_start(1'b0, 3, 2, 1); run_frame(0, 1'b0, 1'b1);
    // Only H words.
    build(1'b1, 0, 2, 0); pulse_start(1'b1, 0, 2, 0); run_frame(0, 1'b0, 1'b0);
    // Empty frame.
    build(1'b1, 0, 0, 0); pulse_start(1'b1, 0, 0, 0); run_frame(0, 1'b0, 1'b0);
    // Five-cycle downstream stall.
    build(1'b1, 3, 2, 1); pulse_start(1'b1, 3, 2, 1); run_frame(1, 1'b0, 1'b0);
`ifdef SIG_FRAMER_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd5);
`endif

    // Reset after two accepted words, then a clean frame.
    build(1'b1, 3, 2, 1); pulse_start(1'b1, 3, 2, 1);
    idx = 0;
    for (int k = 0; k < 20 && idx < 2; k++) begin
      s_valid = 1'b1; s_data = src_q[idx]; m_ready = 1'b1;
      if (s_ready) idx++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midrst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_start_sready", 64'(s_ready), 64'd0);
    end
    s_valid = 1'b0;
    build(1'b0, 3, 2, 1); pulse_start(1'b0, 3, 2, 1); run_frame(0, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      logic ord;
      int   z, h, c;
      ord = 1'($urandom_range(0, 1));
      z = int'($urandom_range(0, 5));
      h = int'($urandom_range(0, 5));
      c = int'($urandom_range(0, 5));
      build(ord, z, h, c); pulse_start(ord, z, h, c); run_frame(2, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
